// File: rtl/spi_register_bank.sv
// rtl/spi_register_bank.sv - write-only SPI slave committing 16-bit frames into five 8-bit PWM control registers
// All SPI lines are oversampled by clk; SCLK is treated as data, never as a clock.
module spi_register_bank #(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_ADDR    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle
);

    localparam logic [6:0] MAX_ADDR_L = 7'(MAX_ADDR);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] copi_sync_q;
    logic [SYNC_STAGES-1:0] ncs_sync_q;
    logic                   sclk_q;
    logic                   ncs_q;

    logic sclk_s;
    logic copi_s;
    logic ncs_s;
    logic sclk_rise;
    logic ncs_fall;
    logic ncs_rise;

    state_t      state_q;
    logic [15:0] shreg_q;
    logic [4:0]  count_q;
    logic        ovf_q;
    logic        commit_ok;

    logic [7:0] out_lo_q;
    logic [7:0] out_hi_q;
    logic [7:0] pwm_lo_q;
    logic [7:0] pwm_hi_q;
    logic [7:0] duty_q;

    // ncs chain resets high so a held-low chip select after reset shows up as a fresh fall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_q <= '0;
            copi_sync_q <= '0;
            ncs_sync_q  <= '1;
            sclk_q      <= 1'b0;
            ncs_q       <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi};
            ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], ncs};
            sclk_q      <= sclk_s;
            ncs_q       <= ncs_s;
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign copi_s    = copi_sync_q[SYNC_STAGES-1];
    assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_q;
    assign ncs_fall  = ~ncs_s & ncs_q;
    assign ncs_rise  = ncs_s & ~ncs_q;

    assign commit_ok = (count_q == 5'd16) && !ovf_q && shreg_q[15]
                       && (shreg_q[14:8] <= MAX_ADDR_L);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            out_lo_q <= '0;
            out_hi_q <= '0;
            pwm_lo_q <= '0;
            pwm_hi_q <= '0;
            duty_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ncs_fall) begin
                        state_q <= SHIFT;
                        shreg_q <= '0;
                        count_q <= '0;
                        ovf_q   <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (ncs_rise) begin
                        state_q <= COMMIT;
                    end else if (ncs_fall) begin
                        shreg_q <= '0;
                        count_q <= '0;
                        ovf_q   <= 1'b0;
                    end else if (sclk_rise && !ncs_s) begin
                        shreg_q <= {shreg_q[14:0], copi_s};
                        if (count_q < 5'd16) begin
                            count_q <= count_q + 5'd1;
                        end else begin
                            ovf_q <= 1'b1;
                        end
                    end
                end
                COMMIT: begin
                    state_q <= IDLE;
                    if (commit_ok) begin
                        case (shreg_q[14:8])
                            7'd0:    out_lo_q <= shreg_q[7:0];
                            7'd1:    out_hi_q <= shreg_q[7:0];
                            7'd2:    pwm_lo_q <= shreg_q[7:0];
                            7'd3:    pwm_hi_q <= shreg_q[7:0];
                            7'd4:    duty_q   <= shreg_q[7:0];
                            default: ;
                        endcase
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign en_reg_out_7_0  = out_lo_q;
    assign en_reg_out_15_8 = out_hi_q;
    assign en_reg_pwm_7_0  = pwm_lo_q;
    assign en_reg_pwm_15_8 = pwm_hi_q;
    assign pwm_duty_cycle  = duty_q;

endmodule

// File: tb/tb_spi_register_bank.sv
// tb/tb_spi_register_bank.sv - directed self-checking bench for spi_register_bank
module tb_spi_register_bank;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk = 1'b0;
    logic       copi = 1'b0;
    logic       ncs = 1'b1;
    logic [7:0] en_reg_out_7_0;
    logic [7:0] en_reg_out_15_8;
    logic [7:0] en_reg_pwm_7_0;
    logic [7:0] en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_out_lo = 8'h00;
    logic [7:0] exp_out_hi = 8'h00;
    logic [7:0] exp_pwm_lo = 8'h00;
    logic [7:0] exp_pwm_hi = 8'h00;
    logic [7:0] exp_duty   = 8'h00;

    spi_register_bank #(
        .SYNC_STAGES(2),
        .MAX_ADDR   (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .sclk           (sclk),
        .copi           (copi),
        .ncs            (ncs),
        .en_reg_out_7_0 (en_reg_out_7_0),
        .en_reg_out_15_8(en_reg_out_15_8),
        .en_reg_pwm_7_0 (en_reg_pwm_7_0),
        .en_reg_pwm_15_8(en_reg_pwm_15_8),
        .pwm_duty_cycle (pwm_duty_cycle)
    );

    always #5 clk = ~clk;

    task automatic wait_clk(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
        end
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, " out_7_0"},  en_reg_out_7_0,  exp_out_lo);
        check({tag, " out_15_8"}, en_reg_out_15_8, exp_out_hi);
        check({tag, " pwm_7_0"},  en_reg_pwm_7_0,  exp_pwm_lo);
        check({tag, " pwm_15_8"}, en_reg_pwm_15_8, exp_pwm_hi);
        check({tag, " duty"},     pwm_duty_cycle,  exp_duty);
    endtask

    // SCLK = clk/8: four clocks low with data set up, four clocks high
    task automatic send_bits(input logic [31:0] val, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            copi = val[i];
            wait_clk(4);
            sclk = 1'b1;
            wait_clk(4);
            sclk = 1'b0;
        end
    endtask

    task automatic frame_begin();
        ncs = 1'b0;
        wait_clk(8);
    endtask

    task automatic frame_end();
        wait_clk(4);
        ncs = 1'b1;
    endtask

    task automatic send_frame(input logic [31:0] val, input int n);
        frame_begin();
        send_bits(val, n);
        frame_end();
        wait_clk(16);
    endtask

    initial begin
        wait_clk(3);
        check_all("reset_asserted");
        rst = 1'b0;
        wait_clk(4);
        check_all("reset_released");

        // 1: single write with exact commit latency
        frame_begin();
        send_bits(32'h80F0, 16);
        frame_end();
        wait_clk(3);
        check("t1 before_latency", en_reg_out_7_0, 8'h00);
        wait_clk(1);
        check("t1 at_latency", en_reg_out_7_0, 8'hF0);
        exp_out_lo = 8'hF0;
        wait_clk(12);
        check_all("t1");

        // 2: back-to-back frames separated by two SCLK periods
        send_frame(32'h8480, 16);
        send_frame(32'h82FF, 16);
        exp_duty   = 8'h80;
        exp_pwm_lo = 8'hFF;
        check_all("t2");

        // 3: read bit and out-of-range addresses are dropped
        send_frame(32'h00AA, 16);
        check_all("t3 read");
        send_frame(32'h85AA, 16);
        check_all("t3 addr5");
        send_frame(32'hFFAA, 16);
        check_all("t3 addr7f");

        // 4: short and long frames dropped, exact length accepted
        send_frame(32'h40AA, 15);
        check_all("t4 short");
        send_frame(32'h102AB, 17);
        check_all("t4 long");
        send_frame(32'h8155, 16);
        exp_out_hi = 8'h55;
        check_all("t4 good");

        // 5: reset in the middle of a frame, released with ncs still low
        frame_begin();
        send_bits(32'h106, 9);
        rst = 1'b1;
        wait_clk(2);
        rst = 1'b0;
        exp_out_lo = 8'h00;
        exp_out_hi = 8'h00;
        exp_pwm_lo = 8'h00;
        exp_pwm_hi = 8'h00;
        exp_duty   = 8'h00;
        check_all("t5 after_reset");
        send_bits(32'h33, 7);
        frame_end();
        wait_clk(16);
        check_all("t5 aborted");
        send_frame(32'h8333, 16);
        exp_pwm_hi = 8'h33;
        check_all("t5 clean");

        // 6a: ncs glitch that falls between two clk edges never reaches the FSM
        frame_begin();
        send_bits(32'h80, 8);
        wait_clk(1);
        #2 ncs = 1'b1;
        #5 ncs = 1'b0;
        wait_clk(1);
        send_bits(32'h11, 8);
        frame_end();
        wait_clk(16);
        exp_out_lo = 8'h11;
        check_all("t6 short_glitch");

        // 6b: four-clock ncs pulse splits the frame into two short ones
        frame_begin();
        send_bits(32'h80, 8);
        ncs = 1'b1;
        wait_clk(4);
        ncs = 1'b0;
        wait_clk(4);
        send_bits(32'h22, 8);
        frame_end();
        wait_clk(16);
        check_all("t6 long_glitch");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
